lcd_bus_responder: RTL and testbench

- Synthesizable model of the display end of the 8-bit HD44780-style LCD bus (`LCD_RS`/`LCD_EN`/`LCD_RW`/`LCD_DATA`) that our LCD controllers drive.
- Captures each write on the falling edge of `LCD_EN`, decodes it as a command or character, maintains a DDRAM shadow, and models the busy flag and address counter.
- Answers busy-flag reads, flags protocol violations, and exposes written characters for on-chip checking of the displayed CRC/status text.

---
 rtl/lcd_pkg.sv | 52 +++++
 rtl/lcd_ddram.sv | 36 +++
 rtl/lcd_bus_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: instruction opcode masks, the ASCII space
// used for clearing, FSM state encodings and a helper that classifies an instruction byte.
// Both the display-side responder and the controllers that drive the bus import this package.
package lcd_pkg;

  // Instruction opcodes. The highest set bit selects the instruction class, so each constant
  // also serves as the mask for that class.
  localparam logic [7:0] OpClear    = 8'h01;
  localparam logic [7:0] OpHome     = 8'h02;
  localparam logic [7:0] OpEntry    = 8'h04;
  localparam logic [7:0] OpDisplay  = 8'h08;
  localparam logic [7:0] OpShift    = 8'h10;
  localparam logic [7:0] OpFuncSet  = 8'h20;
  localparam logic [7:0] OpSetCgram = 8'h40;
  localparam logic [7:0] OpSetDdram = 8'h80;

  localparam logic [7:0] AsciiSpace = 8'h20;

  // Responder FSM state encodings.
  typedef logic [1:0] lcd_state_t;
  localparam lcd_state_t StIdle  = 2'd0;
  localparam lcd_state_t StExec  = 2'd1;
  localparam lcd_state_t StClear = 2'd2;
  localparam lcd_state_t StBusy  = 2'd3;

  typedef enum logic [2:0] {
    CmdNop,
    CmdClear,
    CmdHome,
    CmdEntry,
    CmdDisplay,
    CmdFuncSet,
    CmdSetDdram
  } lcd_cmd_e;

  // Classify an instruction byte by its leading one. Shift, CGRAM address and 0x00 carry no
  // modelled state and map to CmdNop.
  function automatic lcd_cmd_e lcd_decode(input logic [7:0] op);
    lcd_cmd_e cmd;
    if (|(op & OpSetDdram))      cmd = CmdSetDdram;
    else if (|(op & OpSetCgram)) cmd = CmdNop;
    else if (|(op & OpFuncSet))  cmd = CmdFuncSet;
    else if (|(op & OpShift))    cmd = CmdNop;
    else if (|(op & OpDisplay))  cmd = CmdDisplay;
    else if (|(op & OpEntry))    cmd = CmdEntry;
    else if (|(op & OpHome))     cmd = CmdHome;
    else if (|(op & OpClear))    cmd = CmdClear;
    else                         cmd = CmdNop;
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// DDRAM shadow: 2^AW x 8 RAM with one write port and one registered read port.
// Ports: clk_i clock; rst_i async active-high reset (clears only the read register);
//        we_i/waddr_i/wdata_i write port; raddr_i read address; rdata_o registered read data.
module lcd_ddram #(
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// Display end of the 8-bit HD44780-style LCD bus. Synchronizes the asynchronous bus, captures
// writes on the falling edge of EN, decodes instructions and characters, keeps a DDRAM shadow,
// models the busy flag and address counter, answers busy-flag reads and flags protocol errors.
// Ports: clk/rst clock and async active-high reset; LCD_RS/LCD_EN/LCD_RW/LCD_DATA bus inputs;
//        LCD_DATA_OUT/LCD_DATA_OE busy-flag read-back; rd_addr/rd_char shadow read port;
//        char_valid/char_addr/char_data written-character pulse; busy, ac, display_on,
//        init_done status; protocol_err sticky error with err_clr.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned DDRAM_AW     = 5,
  parameter int unsigned BUSY_CYCLES  = 2650,
  parameter int unsigned CLEAR_CYCLES = 150000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                LCD_RS,
  input  logic                LCD_EN,
  input  logic                LCD_RW,
  input  logic [7:0]          LCD_DATA,
  output logic [7:0]          LCD_DATA_OUT,
  output logic                LCD_DATA_OE,
  input  logic [DDRAM_AW-1:0] rd_addr,
  output logic [7:0]          rd_char,
  output logic                char_valid,
  output logic [DDRAM_AW-1:0] char_addr,
  output logic [7:0]          char_data,
  output logic                busy,
  output logic [DDRAM_AW-1:0] ac,
  output logic                display_on,
  output logic                init_done,
  output logic                protocol_err,
  input  logic                err_clr
);

  localparam int unsigned MaxCycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  // EXEC is the first busy cycle, so the counter holds the cycles remaining after it.
  localparam logic [CntW-1:0] BusyLoad  = CntW'(BUSY_CYCLES - 1);
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYCLES - 1);

  // Bus synchronizer: {RS, RW, EN, DATA[7:0]}.
  logic [10:0] sync1_q, sync2_q;
  logic        en_prev_q;
  logic        rs_s, rw_s, en_s;
  logic [7:0]  data_s;
  logic        en_fall, en_rise, wr_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync1_q   <= {LCD_RS, LCD_RW, LCD_EN, LCD_DATA};
      sync2_q   <= sync1_q;
      en_prev_q <= en_s;
    end
  end

  assign rs_s      = sync2_q[10];
  assign rw_s      = sync2_q[9];
  assign en_s      = sync2_q[8];
  assign data_s    = sync2_q[7:0];
  assign en_fall   = en_prev_q & ~en_s;
  assign en_rise   = ~en_prev_q & en_s;
  assign wr_accept = en_fall & ~rw_s;

  lcd_state_t          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DDRAM_AW-1:0] fill_q, fill_d;
  logic [DDRAM_AW-1:0] ac_q, ac_d;
  logic                id_q, id_d;
  logic                disp_q, disp_d;
  logic                init_q, init_d;
  logic                err_q, err_d;
  logic                txn_rs_q, txn_rs_d;
  logic [7:0]          txn_data_q, txn_data_d;

  logic                err_set;
  logic                busy_w;
  logic                ram_we;
  logic [DDRAM_AW-1:0] ram_waddr;
  logic [7:0]          ram_wdata;
  lcd_cmd_e            cmd;

  assign busy_w = (state_q != StIdle);
  assign cmd    = lcd_decode(txn_data_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    init_d     = init_q;
    txn_rs_d   = txn_rs_q;
    txn_data_d = txn_data_q;
    err_set    = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = ac_q;
    ram_wdata  = txn_data_q;

    case (state_q)
      StIdle: begin
        if (wr_accept) begin
          if (rs_s && !init_q) begin
            err_set = 1'b1;
          end else begin
            state_d    = StExec;
            txn_rs_d   = rs_s;
            txn_data_d = data_s;
          end
        end
      end

      StExec: begin
        cnt_d = BusyLoad;
        if (txn_rs_q) begin
          ram_we = 1'b1;
          ac_d   = id_q ? ac_q + DDRAM_AW'(1) : ac_q - DDRAM_AW'(1);
        end else begin
          case (cmd)
            CmdClear: begin
              cnt_d  = ClearLoad;
              ac_d   = '0;
              id_d   = 1'b1;
              fill_d = '0;
            end
            CmdHome: begin
              cnt_d = ClearLoad;
              ac_d  = '0;
            end
            CmdEntry:    id_d   = txn_data_q[1];
            CmdDisplay:  disp_d = txn_data_q[2];
            CmdFuncSet: begin
              if (txn_data_q[4]) init_d  = 1'b1;
              else               err_set = 1'b1;
            end
            CmdSetDdram: ac_d = txn_data_q[DDRAM_AW-1:0];
            default: ;
          endcase
        end

        if (!txn_rs_q && cmd == CmdClear) begin
          state_d = StClear;
        end else begin
          state_d = (cnt_d == '0) ? StIdle : StBusy;
        end
      end

      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = fill_q;
        ram_wdata = AsciiSpace;
        fill_d    = fill_q + DDRAM_AW'(1);
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        // Fill cycles share the clear busy budget; leave early if it is already spent.
        if (&fill_q) begin
          state_d = (cnt_q <= CntW'(1)) ? StIdle : StBusy;
        end
      end

      StBusy: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // A write landing while busy is dropped; data reads are unsupported.
    if (wr_accept && busy_w) err_set = 1'b1;
    if (en_rise && rw_s && rs_s) err_set = 1'b1;

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fill_q     <= '0;
      ac_q       <= '0;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      init_q     <= 1'b0;
      err_q      <= 1'b0;
      txn_rs_q   <= 1'b0;
      txn_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      init_q     <= init_d;
      err_q      <= err_d;
      txn_rs_q   <= txn_rs_d;
      txn_data_q <= txn_data_d;
    end
  end

  lcd_ddram #(
    .AW (DDRAM_AW)
  ) u_ddram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_char)
  );

  assign LCD_DATA_OE  = en_s & rw_s & ~rs_s;
  assign LCD_DATA_OUT = LCD_DATA_OE ? {busy_w, 7'(ac_q)} : 8'h00;

  assign char_valid   = (state_q == StExec) & txn_rs_q;
  assign char_addr    = ac_q;
  assign char_data    = txn_data_q;
  assign busy         = busy_w;
  assign ac           = ac_q;
  assign display_on   = disp_q;
  assign init_done    = init_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed bus sequences followed by random writes, checked
// against a behavioural model of the display (DDRAM array, address counter, flags) and a
// scoreboard of expected character pulses consumed by an independent monitor.
module tb_lcd_bus_responder;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int BUSYC = 8;
  localparam int CLRC  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          LCD_RS = 1'b0, LCD_EN = 1'b0, LCD_RW = 1'b0;
  logic [7:0]    LCD_DATA = 8'h00;
  logic [7:0]    LCD_DATA_OUT;
  logic          LCD_DATA_OE;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_char;
  logic          char_valid;
  logic [AW-1:0] char_addr;
  logic [7:0]    char_data;
  logic          busy;
  logic [AW-1:0] ac;
  logic          display_on, init_done, protocol_err;
  logic          err_clr = 1'b0;

  lcd_bus_responder #(
    .DDRAM_AW     (AW),
    .BUSY_CYCLES  (BUSYC),
    .CLEAR_CYCLES (CLRC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .LCD_RS       (LCD_RS),
    .LCD_EN       (LCD_EN),
    .LCD_RW       (LCD_RW),
    .LCD_DATA     (LCD_DATA),
    .LCD_DATA_OUT (LCD_DATA_OUT),
    .LCD_DATA_OE  (LCD_DATA_OE),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .char_valid   (char_valid),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .busy         (busy),
    .ac           (ac),
    .display_on   (display_on),
    .init_done    (init_done),
    .protocol_err (protocol_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the display.
  logic [7:0]    m_mem [DEPTH];
  bit            m_known [DEPTH];
  logic [AW-1:0] m_ac;
  bit            m_id, m_disp, m_init, m_err;
  logic [12:0]   exp_q [$];   // {addr, data} of expected character pulses

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && char_valid) begin
      if (exp_q.size() == 0) begin
        check("char_spurious", {19'd0, char_addr, char_data}, 32'hFFFF_FFFF);
      end else begin
        check("char_pulse", {19'd0, char_addr, char_data}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic model_reset();
    m_ac = '0; m_id = 1'b1; m_disp = 1'b0; m_init = 1'b0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  endtask

  // Applies one idle-time write to the model; returns the expected busy length in cycles.
  function automatic int model_write(input bit rs, input logic [7:0] d);
    int v;
    v = int'(d);
    if (rs) begin
      if (!m_init) begin
        m_err = 1'b1;
        return 0;
      end
      exp_q.push_back({m_ac, d});
      m_mem[m_ac]   = d;
      m_known[m_ac] = 1'b1;
      m_ac = m_id ? AW'((int'(m_ac) + 1) % DEPTH) : AW'((int'(m_ac) + DEPTH - 1) % DEPTH);
      return BUSYC;
    end
    if (v == 1) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = 8'h20; m_known[i] = 1'b1;
      end
      m_ac = '0; m_id = 1'b1;
      return CLRC;
    end
    if (v == 2 || v == 3) begin
      m_ac = '0;
      return CLRC;
    end
    if (v >= 4 && v <= 7)         m_id = d[1];
    else if (v >= 8 && v <= 15)   m_disp = d[2];
    else if (v >= 32 && v <= 63) begin
      if (d[4]) m_init = 1'b1;
      else      m_err  = 1'b1;
    end else if (v >= 128)        m_ac = AW'(v % DEPTH);
    return BUSYC;
  endfunction

  task automatic drive_write(input bit rs, input logic [7:0] d);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d;
    @(negedge clk);
    LCD_EN = 1'b1;
    repeat (2) @(negedge clk);
    LCD_EN = 1'b0;
  endtask

  // Counts busy-high cycles following an EN fall; bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (i >= 3) break;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 200) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"},   32'(ac), 32'(m_ac));
    check({tag, "_disp"}, 32'(display_on), 32'(m_disp));
    check({tag, "_init"}, 32'(init_done), 32'(m_init));
    check({tag, "_err"},  32'(protocol_err), 32'(m_err));
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] d);
    int exp_n, n;
    exp_n = model_write(rs, d);
    drive_write(rs, d);
    count_busy(n);
    check("busy_len", n, exp_n);
    check_state("wr");
  endtask

  task automatic bus_read(input bit rs, input logic [7:0] exp);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = 1'b1;
    @(negedge clk);
    LCD_EN = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_oe", 32'(LCD_DATA_OE), rs ? 32'd0 : 32'd1);
    if (!rs) check("rd_data", 32'(LCD_DATA_OUT), 32'(exp));
    LCD_EN = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_oe_off", 32'(LCD_DATA_OE), 32'd0);
    @(negedge clk);
    LCD_RW = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(protocol_err), 32'd0);
  endtask

  task automatic check_mem(input int a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = AW'(a);
    @(negedge clk);
    check("rd_char", 32'(rd_char), 32'(exp));
  endtask

  task automatic verify_mem();
    for (int a = 0; a < DEPTH; a++) begin
      if (m_known[a]) check_mem(a, m_mem[a]);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] d;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ac",    32'(ac), 32'd0);
    check("rst_cv",    32'(char_valid), 32'd0);
    check("rst_oe",    32'(LCD_DATA_OE), 32'd0);
    check("rst_out",   32'(LCD_DATA_OUT), 32'd0);
    check("rst_rdch",  32'(rd_char), 32'd0);
    check_state("rst");
    rst = 1'b0;

    // Character before init: dropped, error raised.
    bus_write(1'b1, 8'h41);
    pulse_err_clr();

    // 1: init sequence.
    bus_write(1'b0, 8'h38);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b0, 8'h06);
    bus_write(1'b0, 8'h01);
    check("t1_init", 32'(init_done), 32'd1);
    check("t1_disp", 32'(display_on), 32'd1);
    verify_mem();

    // 2: "CRC".
    bus_write(1'b1, 8'h43);
    bus_write(1'b1, 8'h52);
    bus_write(1'b1, 8'h43);
    check_mem(1, 8'h52);
    check("t2_ac", 32'(ac), 32'd3);

    // 3: wrap forward then backward.
    bus_write(1'b0, 8'h9F);
    bus_write(1'b1, 8'h58);
    check("t3_wrap0", 32'(ac), 32'd0);
    bus_write(1'b0, 8'h04);
    bus_write(1'b1, 8'h59);
    check("t3_wrap31", 32'(ac), 32'd31);
    check_mem(31, 8'h58);
    check_mem(0, 8'h59);
    bus_write(1'b0, 8'h06);

    // Function set with DL=0.
    bus_write(1'b0, 8'h28);
    check("dl0_err", 32'(protocol_err), 32'd1);
    pulse_err_clr();

    // 4: write while busy is dropped.
    void'(model_write(1'b0, 8'h0C));
    drive_write(1'b0, 8'h0C);
    repeat (3) @(negedge clk);
    drive_write(1'b1, 8'h5A);
    m_err = 1'b1;
    wait_idle();
    check_state("t4");
    pulse_err_clr();

    // 5: busy-flag read during clear, then after.
    void'(model_write(1'b0, 8'h01));
    drive_write(1'b0, 8'h01);
    repeat (3) @(negedge clk);
    bus_read(1'b0, 8'h80);
    wait_idle();
    bus_read(1'b0, 8'h00);
    check_state("t5");

    // Data read is unsupported.
    bus_read(1'b1, 8'h00);
    m_err = 1'b1;
    check("dread_err", 32'(protocol_err), 32'd1);
    pulse_err_clr();

    // 6: reset mid-clear.
    void'(model_write(1'b0, 8'h01));
    drive_write(1'b0, 8'h01);
    repeat (10) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ac", 32'(ac), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus_write(1'b0, 8'h38);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b0, 8'h06);
    bus_write(1'b0, 8'h01);

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 99));
      d = 8'($urandom);
      if (r < 55)      bus_write(1'b1, 8'($urandom_range(32, 126)));
      else if (r < 68) bus_write(1'b0, {1'b1, d[6:0]});
      else if (r < 78) bus_write(1'b0, {6'b000001, d[1:0]});
      else if (r < 86) bus_write(1'b0, {5'b00001, d[2:0]});
      else if (r < 90) bus_write(1'b0, d[0] ? {4'b0001, d[3:0]} : {2'b01, d[5:0]});
      else if (r < 93) bus_write(1'b0, {7'b0000001, d[0]});
      else             bus_read(1'b0, {1'b0, 7'(m_ac)});
    end
    verify_mem();

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
